// File: rtl/picoblaze_irq_controller.sv
// rtl/picoblaze_irq_controller.sv - edge-latched, masked, fixed-priority interrupt controller for the pacoblaze3 core
module picoblaze_irq_controller #(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] CAUSE_PORT   = 8'h01,
  parameter logic [7:0] PENDING_PORT = 8'h02,
  parameter logic [7:0] MASK_PORT    = 8'h04,
  parameter logic [7:0] EOI_PORT     = 8'h08
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         out_port,
  output logic [7:0]         rd_data,
  output logic               interrupt,
  input  logic               interrupt_ack,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [2:0]         win_q, win_d;
  logic               interrupt_q, interrupt_d;
  logic               busy_q, busy_d;
  logic [7:0]         rd_data_q, rd_data_d;

  logic [NUM_SRC-1:0] rise, eligible, clr;
  logic [2:0]         win_sel;
  logic               mask_wr, eoi_wr;

  // Reads have no side effects and mask bits above NUM_SRC are never stored.
  logic unused_ok;
  assign unused_ok = &{1'b0, read_strobe, out_port};

  assign mask_wr  = write_strobe && (port_id == MASK_PORT);
  assign eoi_wr   = write_strobe && (port_id == EOI_PORT);
  assign rise     = irq_src & ~prev_q;
  assign eligible = pending_q & mask_q;

  // Lowest set index wins.
  always_comb begin
    win_sel = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_sel = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    busy_d      = busy_q;
    win_d       = win_q;
    clr         = '0;
    prev_d      = irq_src;
    mask_d      = mask_wr ? out_port[NUM_SRC-1:0] : mask_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          win_d       = win_sel;
          interrupt_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          interrupt_d = 1'b0;
          clr         = NUM_SRC'(1) << win_q;
          state_d     = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        interrupt_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // A new edge in the ack cycle outranks the clear, so the source re-pends.
    pending_d = (pending_q & ~clr) | rise;

    if (port_id == CAUSE_PORT)        rd_data_d = {busy_q, 4'b0000, win_q};
    else if (port_id == PENDING_PORT) rd_data_d = 8'(pending_q);
    else                              rd_data_d = 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      win_q       <= 3'd0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      win_q       <= win_d;
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign interrupt = interrupt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_picoblaze_irq_controller.sv
// tb/tb_picoblaze_irq_controller.sv - scoreboard bench for picoblaze_irq_controller
module tb_picoblaze_irq_controller;

  localparam int W_RD  = 0;
  localparam int W_INT = 1;
  localparam int W_BSY = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] irq_src = 4'h0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] rd_data;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic       busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         due;
    int         what;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  picoblaze_irq_controller #(.NUM_SRC(4)) dut (
    .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .port_id(port_id),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .out_port(out_port),
    .rd_data(rd_data), .interrupt(interrupt), .interrupt_ack(interrupt_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every scoreboard entry due at the edge just passed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [7:0] act;
        case (sb[i].what)
          W_RD:    act = rd_data;
          W_INT:   act = {7'b0, interrupt};
          default: act = {7'b0, busy};
        endcase
        total = total + 1;
        if (act !== sb[i].exp) begin
          bad = bad + 1;
          $display("FAIL %s: got %02h expected %02h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int what, input logic [7:0] exp, input string name);
    exp_t e;
    e.due = cyc; e.what = what; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    port_id = addr; read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0; port_id = 8'h00;
    expect_now(W_RD, exp, name);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    expect_now(W_INT, 8'h00, "reset_int");
    expect_now(W_BSY, 8'h00, "reset_busy");
    expect_now(W_RD,  8'h00, "reset_rd");

    // Single source
    wr(8'h04, 8'h0F);
    irq_src = 4'b0100; tick(); irq_src = 4'b0000;
    expect_now(W_INT, 8'h00, "single_int_n");
    tick();
    expect_now(W_INT, 8'h01, "single_int_n1");
    expect_now(W_BSY, 8'h01, "single_busy_req");
    rd(8'h01, 8'h82, "single_cause");
    ack();
    expect_now(W_INT, 8'h00, "single_ack_int");
    expect_now(W_BSY, 8'h01, "single_ack_busy");
    rd(8'h02, 8'h00, "single_pending");
    wr(8'h08, 8'h00);
    expect_now(W_BSY, 8'h00, "single_eoi_busy");

    // Priority
    irq_src = 4'b1010; tick(); irq_src = 4'b0000;
    tick();
    expect_now(W_INT, 8'h01, "prio_int1");
    rd(8'h01, 8'h81, "prio_cause1");
    ack();
    wr(8'h08, 8'h00);
    expect_now(W_INT, 8'h00, "prio_eoi_int");
    tick();
    expect_now(W_INT, 8'h01, "prio_int2");
    rd(8'h01, 8'h83, "prio_cause2");
    ack();
    wr(8'h08, 8'h00);

    // Masking
    wr(8'h04, 8'h00);
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_now(W_INT, 8'h00, "mask_hold");
    end
    rd(8'h02, 8'h01, "mask_pending");
    wr(8'h04, 8'h01);
    expect_now(W_INT, 8'h00, "mask_wr_edge");
    tick();
    expect_now(W_INT, 8'h01, "mask_enable_int");

    // Misuse: EOI in REQ, ack in IDLE
    wr(8'h08, 8'h00);
    expect_now(W_INT, 8'h01, "eoi_in_req_int");
    expect_now(W_BSY, 8'h01, "eoi_in_req_busy");
    rd(8'h01, 8'h80, "eoi_in_req_cause");
    ack();
    expect_now(W_INT, 8'h00, "misuse_ack_int");
    wr(8'h08, 8'h00);
    expect_now(W_BSY, 8'h00, "misuse_eoi_busy");
    ack();
    expect_now(W_BSY, 8'h00, "ack_idle_busy");
    expect_now(W_INT, 8'h00, "ack_idle_int");
    rd(8'h01, 8'h00, "ack_idle_cause");

    // Re-pend on ack cycle
    wr(8'h04, 8'h0F);
    irq_src = 4'b0010; tick(); irq_src = 4'b0000;
    tick();
    expect_now(W_INT, 8'h01, "repend_int1");
    irq_src = 4'b0010; interrupt_ack = 1'b1;
    tick();
    irq_src = 4'b0000; interrupt_ack = 1'b0;
    expect_now(W_INT, 8'h00, "repend_ack_int");
    rd(8'h02, 8'h02, "repend_pending");
    wr(8'h08, 8'h00);
    expect_now(W_INT, 8'h00, "repend_eoi_int");
    tick();
    expect_now(W_INT, 8'h01, "repend_int2");
    rd(8'h01, 8'h81, "repend_cause");

    // Reset mid-REQ, checked between clock edges
    tick();
    reset_n = 1'b0;
    #1;
    total = total + 1;
    if (interrupt !== 1'b0 || busy !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL async_reset: got int=%0b busy=%0b expected int=0 busy=0", interrupt, busy);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    rd(8'h02, 8'h00, "post_reset_pending");
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_now(W_INT, 8'h00, "post_reset_mask");
    end
    rd(8'h02, 8'h01, "post_reset_pending2");

    repeat (3) tick();
    while (sb.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL unchecked_%s: got none expected %02h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
